// File: rtl/mul_seq_pkg.sv
// Shared types for the sequential multiplier.
// Holds the FSM state encoding used by mul_seq.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_CALC = 2'd1,
        MUL_FIX  = 2'd2,
        MUL_DONE = 2'd3
    } mul_state_t;

endpackage

// File: rtl/mul_add.sv
// Adder used by the multiplier shift-add step: {cout,sum} = op_a + op_b + cin.
// Ports: op_a, op_b (DATA_LEN), cin -> sum (DATA_LEN), cout.
module mul_add #(
    parameter int DATA_LEN = 32
) (
    input  logic [DATA_LEN-1:0] op_a,
    input  logic [DATA_LEN-1:0] op_b,
    input  logic                cin,
    output logic [DATA_LEN-1:0] sum,
    output logic                cout
);

    assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b}
                       + {{DATA_LEN{1'b0}}, cin};

endmodule

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier with per-operand signedness.
// Ports: clk, rst (sync, high), flush; in_valid/in_ready with op_a, op_b,
// a_signed, b_signed; out_valid/out_ready with the 2*DATA_LEN product.
module mul_seq
    import mul_seq_pkg::*;
#(
    parameter int DATA_LEN = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_LEN-1:0]   op_a,
    input  logic [DATA_LEN-1:0]   op_b,
    input  logic                  a_signed,
    input  logic                  b_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [2*DATA_LEN-1:0] product
);

    localparam int CW = $clog2(DATA_LEN);
    localparam int PW = 2 * DATA_LEN;
    localparam logic [CW-1:0] LAST = CW'(DATA_LEN - 1);

    mul_state_t state;
    mul_state_t state_nxt;

    logic [DATA_LEN-1:0] mag_a;
    logic [PW-1:0]       acc;
    logic                neg;
    logic [CW-1:0]       cnt;
    logic [PW-1:0]       prod_q;

    logic                sa;
    logic                sb;
    logic [DATA_LEN-1:0] abs_a;
    logic [DATA_LEN-1:0] abs_b;
    logic [DATA_LEN-1:0] addend;
    logic [DATA_LEN-1:0] sum;
    logic                cout;
    logic                accept;

    // Magnitudes are taken as unsigned, so the most negative value
    // maps to 2^(N-1) without overflow.
    assign sa    = a_signed & op_a[DATA_LEN-1];
    assign sb    = b_signed & op_b[DATA_LEN-1];
    assign abs_a = sa ? (~op_a + DATA_LEN'(1)) : op_a;
    assign abs_b = sb ? (~op_b + DATA_LEN'(1)) : op_b;

    assign addend = acc[0] ? mag_a : '0;
    assign accept = in_valid & in_ready & ~flush;

    mul_add #(
        .DATA_LEN(DATA_LEN)
    ) u_add (
        .op_a (acc[PW-1:DATA_LEN]),
        .op_b (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MUL_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            MUL_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = MUL_CALC;
                end
            end
            MUL_CALC: begin
                if (cnt == LAST) begin
                    state_nxt = MUL_FIX;
                end
            end
            MUL_FIX: begin
                state_nxt = MUL_DONE;
            end
            MUL_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = MUL_IDLE;
                end
            end
        endcase
        // Flush beats every transition, including acceptance in IDLE.
        if (flush) begin
            state_nxt = MUL_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mag_a  <= '0;
            acc    <= '0;
            neg    <= 1'b0;
            cnt    <= '0;
            prod_q <= '0;
        end else if (accept) begin
            mag_a <= abs_a;
            acc   <= {{DATA_LEN{1'b0}}, abs_b};
            neg   <= sa ^ sb;
            cnt   <= '0;
        end else if (!flush && state == MUL_CALC) begin
            // Add into the high half, then shift the whole
            // {carry, high, low} right by one.
            acc <= {cout, sum, acc[DATA_LEN-1:1]};
            cnt <= cnt + CW'(1);
        end else if (!flush && state == MUL_FIX) begin
            prod_q <= neg ? (~acc + PW'(1)) : acc;
        end
    end

    assign product = prod_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed and randomised checks for mul_seq at DATA_LEN=32.
// Each task drives one scenario and compares outputs inline.
module tb_mul_seq;

    localparam int N = 32;

    logic           clk;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_b;
    logic           a_signed;
    logic           b_signed;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;

    int errors = 0;
    int checks = 0;

    mul_seq #(
        .DATA_LEN(N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .a_signed  (a_signed),
        .b_signed  (b_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sa,
        input logic        sb
    );
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return ea * eb;
    endfunction

    // Present operands for one cycle, then scramble them so that
    // late changes would corrupt the result if they were sampled.
    task automatic start_op(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        sa,
        input logic        sb
    );
        op_a     = a;
        op_b     = b;
        a_signed = sa;
        b_signed = sb;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a     = ~a;
        op_b     = ~b;
        a_signed = ~sa;
        b_signed = ~sb;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (product !== 64'h0) begin
            errors++;
            $display("FAIL reset_product got=%h exp=0", product);
        end
        rst = 1'b0;
    endtask

    task automatic test_unsigned;
        int lat;
        start_op(32'd3, 32'd5, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL latency_3x5 got=%0d exp=33", lat);
        end
        checks++;
        if (product !== 64'h0000_0000_0000_000F) begin
            errors++;
            $display("FAIL prod_3x5 got=%h exp=f", product);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_done rdy=%b vld=%b exp=1/0",
                     in_ready, out_valid);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (product !== 64'h0000_0000_0000_000F) begin
            errors++;
            $display("FAIL prod_hold_idle got=%h exp=f", product);
        end
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if (product !== 64'hFFFF_FFFE_0000_0001) begin
            errors++;
            $display("FAIL prod_umax got=%h exp=fffffffe00000001",
                     product);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_signed;
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic        vsa [5];
        logic        vsb [5];
        logic [63:0] vexp [5];
        int          lat;
        va[0] = 32'h8000_0000; vb[0] = 32'h0000_0001;
        vsa[0] = 1'b1; vsb[0] = 1'b1; vexp[0] = 64'hFFFF_FFFF_8000_0000;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'hFFFF_FFFF;
        vsa[1] = 1'b1; vsb[1] = 1'b1; vexp[1] = 64'h1;
        va[2] = 32'hFFFF_FFFF; vb[2] = 32'h0000_0002;
        vsa[2] = 1'b1; vsb[2] = 1'b0; vexp[2] = 64'hFFFF_FFFF_FFFF_FFFE;
        va[3] = 32'h0000_0000; vb[3] = 32'hFFFF_FFFF;
        vsa[3] = 1'b0; vsb[3] = 1'b1; vexp[3] = 64'h0;
        va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000;
        vsa[4] = 1'b1; vsb[4] = 1'b1; vexp[4] = 64'h4000_0000_0000_0000;
        for (int i = 0; i < 5; i++) begin
            start_op(va[i], vb[i], vsa[i], vsb[i]);
            wait_done(lat);
            checks++;
            if (lat !== 33 || product !== vexp[i]) begin
                errors++;
                $display("FAIL signed_vec%0d got=%h lat=%0d exp=%h lat=33",
                         i, product, lat, vexp[i]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_backpressure;
        int lat;
        out_ready = 1'b0;
        start_op(32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if (product !== 64'h0000_0000_0001_2340) begin
            errors++;
            $display("FAIL bp_prod got=%h exp=12340", product);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                product !== 64'h0000_0000_0001_2340) begin
                errors++;
                $display("FAIL bp_hold%0d vld=%b rdy=%b prod=%h exp=1/0/12340",
                         i, out_valid, in_ready, product);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release vld=%b rdy=%b exp=0/1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_flush;
        int lat;
        bit seen;
        start_op(32'd100, 32'd200, 1'b0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle rdy=%b vld=%b exp=1/0",
                     in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL flush_dropped got=out_valid exp=none");
        end
        op_a     = 32'd9;
        op_b     = 32'd9;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || product !== 64'h0000_0000_0001_2340) begin
            errors++;
            $display("FAIL flush_vs_accept rdy=%b prod=%h exp=1/12340",
                     in_ready, product);
        end
        start_op(32'd7, 32'd6, 1'b0, 1'b0);
        wait_done(lat);
        checks++;
        if (lat !== 33 || product !== 64'd42) begin
            errors++;
            $display("FAIL after_flush got=%h lat=%0d exp=2a lat=33",
                     product, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op;
        int lat;
        start_op(32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 64'h0) begin
            errors++;
            $display("FAIL rst_mid rdy=%b vld=%b prod=%h exp=1/0/0",
                     in_ready, out_valid, product);
        end
        start_op(32'd11, 32'hFFFF_FFFD, 1'b0, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 33 || product !== 64'hFFFF_FFFF_FFFF_FFDF) begin
            errors++;
            $display("FAIL after_rst got=%h lat=%0d exp=ffffffffffffffdf",
                     product, lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        logic        sa;
        logic        sb;
        logic [63:0] exp;
        int          lat;
        int          hold;
        for (int i = 0; i < 300; i++) begin
            a  = $urandom;
            b  = $urandom;
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = 32'h8000_0000;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h0;
                default: ;
            endcase
            exp       = ref_mul(a, b, sa, sb);
            out_ready = 1'b0;
            start_op(a, b, sa, sb);
            wait_done(lat);
            hold = $urandom_range(0, 3);
            repeat (hold) @(posedge clk);
            #1;
            checks++;
            if (lat !== 33 || out_valid !== 1'b1 || product !== exp) begin
                errors++;
                $display("FAIL rand%0d a=%h b=%h s=%b%b got=%h lat=%0d exp=%h",
                         i, a, b, sa, sb, product, lat, exp);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        out_ready = 1'b1;
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_flush();
        test_reset_mid_op();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
